lif_neuron_array: RTL and testbench
===================================

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  N_NEURONS, 8, neuron count (>=2)
  V_WIDTH, 16, signed membrane/accumulator width
  THRESHOLD, 1000, signed firing threshold
  LEAK_SHIFT, 2, leak = v >>> LEAK_SHIFT
  REFRACT, 2, refractory ticks after a spike (0 = none)
  IDX_W, $clog2(N_NEURONS), neuron index width
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk  in  1  clock
  rst  in  1  asynchronous, active-high reset
  in_valid  in  1  synaptic input event valid
  in_ready  out  1  event accepted when in_valid && in_ready
  in_idx  in  IDX_W  target neuron
  in_weight  in  V_WIDTH  signed weighted input
  tick  in  1  timestep strobe, single-cycle
  busy  out  1  scan in progress
  tick_overrun  out  1  one-cycle pulse: tick arrived while busy
  spk_valid  out  1  spike event valid
  spk_ready  in  1  spike consumer ready
  spk_idx  out  IDX_W  index of spiking neuron

Function
REQ-003 The FSM SHALL have states IDLE, SCAN, and SPIKE_WAIT.
REQ-004 In IDLE: in_ready=1, busy=0. An accepted event SHALL add in_weight to acc[in_idx] with signed saturation.
REQ-005 Events with in_idx >= N_NEURONS SHALL be accepted and discarded.
REQ-006 tick in IDLE SHALL move to SCAN with i=0 on the next edge.
REQ-007 If tick and an accepted event coincide, the event SHALL be included in this timestep's scan.
REQ-008 In SCAN and SPIKE_WAIT: in_ready=0, busy=1.
REQ-009 tick while busy SHALL be ignored and SHALL pulse tick_overrun for one cycle.
REQ-010 SCAN SHALL process one neuron per cycle, i = 0..N_NEURONS-1 ascending.
REQ-011 If refr[i] > 0 for the neuron being processed:
  - refr[i] decrements
  - v[i] = 0
  - acc[i] = 0
  - no spike
REQ-012 Otherwise:
  - vn = sat(v[i] + acc[i] - (v[i] >>> LEAK_SHIFT)), computed at V_WIDTH+2 bits, then clamped to [-2^(V_WIDTH-1), 2^(V_WIDTH-1)-1]
  - acc[i] = 0
  - if vn >= THRESHOLD (signed): spike, v[i] = 0, refr[i] = REFRACT
  - else: v[i] = vn
REQ-013 On a spike, the next edge SHALL register spk_valid=1 and spk_idx=i.
REQ-014 spk_valid and spk_idx SHALL hold stable until spk_valid && spk_ready.
REQ-015 While an unaccepted spike is pending, the FSM SHALL sit in SPIKE_WAIT and SHALL NOT process the next neuron.
REQ-016 When spk_ready=1 throughout, the scan SHALL take exactly N_NEURONS cycles with no bubbles, and spk_valid SHALL drop the cycle after acceptance.
REQ-017 After neuron N_NEURONS-1 is processed and any final spike is accepted, the FSM SHALL return to IDLE.
REQ-018 Spike order SHALL be ascending index, at most one spike per neuron per tick.

Reset
REQ-019 rst SHALL force the following, regardless of state (including mid-scan):
  - FSM = IDLE, i = 0
  - all v, acc, refr = 0
  - spk_valid = 0, spk_idx = 0, tick_overrun = 0, busy = 0
REQ-020 During reset, in_ready SHALL read 1 (IDLE).

Structure
REQ-021 Package snn_pkg SHALL hold:
  - the FSM state enum
  - the saturating-add function
  - the default THRESHOLD/LEAK_SHIFT constants
REQ-022 The per-neuron update (REQ-011/012) SHALL be a combinational sub-module lif_update, instantiated once and shared by the scan.
REQ-023 v, acc and refr SHALL be register arrays indexed by neuron.

Verification (N_NEURONS=4, V_WIDTH=16, THRESHOLD=1000, LEAK_SHIFT=2, REFRACT=2)
REQ-024 Reset/idle: assert rst mid-scan -> next cycle busy=0, in_ready=1, spk_valid=0; a following tick with no events -> 4 busy cycles, no spikes.
REQ-025 Integrate and fire on neuron 1:
  - event (1, 600), tick -> no spike, v[1]=600
  - event (1, 600), tick -> 600+600-150 = 1050, spk_valid with spk_idx=1 on scan cycle 2, v[1]=0
REQ-026 Refractory on neuron 1, after the spike:
  - event (1, 2000) + tick, twice -> no spikes
  - third tick with (1, 2000) -> spike idx 1
REQ-027 Backpressure:
  - events (0, 1500) and (2, 1500), tick, spk_ready=0 for 5 cycles -> spk_valid=1, spk_idx=0 held, busy=1
  - spk_ready=1 -> idx 0 then idx 2 accepted, IDLE after neuron 3
REQ-028 Saturation: two events (3, 32767) -> acc[3]=32767, then spike; two events (3, -32768) -> acc=-32768, v[3]=-32768, no spike.
REQ-029 Overrun and coincidence:
  - tick during scan -> tick_overrun pulse, scan unaffected
  - event (2, 1200) in the same cycle as tick -> spike idx 2 this timestep
  - event idx 5 -> accepted, no state change

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the LIF neuron array.
// Holds the scan FSM encoding, default neuron constants and saturating math.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SCAN       = 2'd1,
    SPIKE_WAIT = 2'd2
  } lif_state_t;

  localparam int DEF_THRESHOLD  = 1000;
  localparam int DEF_LEAK_SHIFT = 2;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end
    if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    return sat_clamp(a + b, w);
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leaky-integrate-and-fire step for one neuron.
// Shared by the scan; the caller always clears the accumulator afterwards.
module lif_update
  import snn_pkg::*;
#(
  parameter int V_WIDTH    = 16,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRACT    = 2,
  parameter int RW         = 2
) (
  input  logic signed [V_WIDTH-1:0] v,
  input  logic signed [V_WIDTH-1:0] acc,
  input  logic        [RW-1:0]      refr,
  output logic signed [V_WIDTH-1:0] v_next,
  output logic        [RW-1:0]      refr_next,
  output logic                      spike
);

  localparam int EW = V_WIDTH + 2;
  localparam logic signed [V_WIDTH-1:0] THR = V_WIDTH'(THRESHOLD);

  logic signed [EW-1:0] v_ext;
  logic signed [EW-1:0] acc_ext;
  logic signed [EW-1:0] leak_ext;
  logic signed [EW-1:0] sum;
  logic signed [V_WIDTH-1:0] vn;

  // Two guard bits make the three-term sum exact before clamping.
  assign v_ext    = v;
  assign acc_ext  = acc;
  assign leak_ext = v >>> LEAK_SHIFT;
  assign sum      = v_ext + acc_ext - leak_ext;
  assign vn       = V_WIDTH'(sat_clamp(sum, V_WIDTH));

  always_comb begin
    v_next    = '0;
    refr_next = '0;
    spike     = 1'b0;
    if (refr != '0) begin
      refr_next = refr - RW'(1);
    end else if (vn >= THR) begin
      spike     = 1'b1;
      refr_next = RW'(REFRACT);
    end else begin
      v_next = vn;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of LIF neurons: events integrate into per-neuron accumulators while idle,
// and each tick triggers an in-order scan that emits spikes over a ready/valid port.
module lif_neuron_array
  import snn_pkg::*;
#(
  parameter int N_NEURONS  = 8,
  parameter int V_WIDTH    = 16,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRACT    = 2,
  parameter int IDX_W      = $clog2(N_NEURONS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic        [IDX_W-1:0]   in_idx,
  input  logic signed [V_WIDTH-1:0] in_weight,
  input  logic                      tick,
  output logic                      busy,
  output logic                      tick_overrun,
  output logic                      spk_valid,
  input  logic                      spk_ready,
  output logic        [IDX_W-1:0]   spk_idx
);

  localparam int CW = $clog2(N_NEURONS + 1);
  localparam int RW = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_NEURONS - 1);
  localparam logic [CW-1:0] END_IDX  = CW'(N_NEURONS);

  lif_state_t                state_reg;
  logic [CW-1:0]             idx_reg;
  logic                      spk_valid_reg;
  logic [IDX_W-1:0]          spk_idx_reg;
  logic                      overrun_reg;

  logic signed [V_WIDTH-1:0] v_reg    [N_NEURONS];
  logic signed [V_WIDTH-1:0] acc_reg  [N_NEURONS];
  logic        [RW-1:0]      refr_reg [N_NEURONS];

  logic [IDX_W-1:0]          scan_idx;
  logic                      process_en;
  logic [N_NEURONS-1:0]      ev_hit;
  logic [N_NEURONS-1:0]      upd_hit;
  logic signed [V_WIDTH-1:0] acc_ev;
  logic signed [V_WIDTH-1:0] upd_v;
  logic        [RW-1:0]      upd_refr;
  logic                      upd_spike;

  assign in_ready     = (state_reg == IDLE);
  assign busy         = !in_ready;
  assign tick_overrun = overrun_reg;
  assign spk_valid    = spk_valid_reg;
  assign spk_idx      = spk_idx_reg;
  assign scan_idx     = idx_reg[IDX_W-1:0];

  // A pending spike that is being accepted this cycle lets the next neuron proceed.
  assign process_en = (state_reg == SCAN) ||
                      ((state_reg == SPIKE_WAIT) && spk_ready && (idx_reg != END_IDX));

  assign acc_ev = V_WIDTH'(sat_add(acc_reg[in_idx], in_weight, V_WIDTH));

  lif_update #(
    .V_WIDTH   (V_WIDTH),
    .THRESHOLD (THRESHOLD),
    .LEAK_SHIFT(LEAK_SHIFT),
    .REFRACT   (REFRACT),
    .RW        (RW)
  ) u_update (
    .v        (v_reg[scan_idx]),
    .acc      (acc_reg[scan_idx]),
    .refr     (refr_reg[scan_idx]),
    .v_next   (upd_v),
    .refr_next(upd_refr),
    .spike    (upd_spike)
  );

  // Out-of-range event indices match no neuron and are silently dropped.
  generate
    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_hit
      assign ev_hit[gi]  = in_valid && in_ready && (in_idx == IDX_W'(gi));
      assign upd_hit[gi] = process_en && (idx_reg == CW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        v_reg[n]    <= '0;
        acc_reg[n]  <= '0;
        refr_reg[n] <= '0;
      end
    end else begin
      for (int n = 0; n < N_NEURONS; n++) begin
        if (upd_hit[n]) begin
          v_reg[n]    <= upd_v;
          acc_reg[n]  <= '0;
          refr_reg[n] <= upd_refr;
        end else if (ev_hit[n]) begin
          acc_reg[n] <= acc_ev;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      spk_valid_reg <= 1'b0;
      spk_idx_reg   <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      overrun_reg <= tick && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (tick) begin
            state_reg <= SCAN;
            idx_reg   <= '0;
          end
        end
        SCAN, SPIKE_WAIT: begin
          if (process_en) begin
            idx_reg <= idx_reg + CW'(1);
            if (upd_spike) begin
              spk_valid_reg <= 1'b1;
              spk_idx_reg   <= scan_idx;
              state_reg     <= SPIKE_WAIT;
            end else begin
              spk_valid_reg <= 1'b0;
              state_reg     <= (idx_reg == LAST_IDX) ? IDLE : SCAN;
            end
          end else if ((state_reg == SPIKE_WAIT) && spk_ready) begin
            spk_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: a behavioural neuron model predicts spikes
// per tick, and a monitor compares every accepted spike against the queue.
module tb_lif_neuron_array;

  localparam int N   = 4;
  localparam int VW  = 16;
  localparam int IW  = 2;
  localparam int THR = 1000;
  localparam int LS  = 2;
  localparam int RF  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 in_valid  = 1'b0;
  logic                 in_ready;
  logic [IW-1:0]        in_idx    = '0;
  logic signed [VW-1:0] in_weight = '0;
  logic                 tick      = 1'b0;
  logic                 busy;
  logic                 tick_overrun;
  logic                 spk_valid;
  logic                 spk_ready = 1'b1;
  logic [IW-1:0]        spk_idx;

  lif_neuron_array #(
    .N_NEURONS(N), .V_WIDTH(VW), .THRESHOLD(THR), .LEAK_SHIFT(LS), .REFRACT(RF), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .in_weight(in_weight), .tick(tick), .busy(busy), .tick_overrun(tick_overrun),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx)
  );

  // Second instance with a non-power-of-two count so out-of-range indices are expressible.
  logic                 b_in_valid = 1'b0;
  logic                 b_in_ready;
  logic [2:0]           b_in_idx   = '0;
  logic signed [VW-1:0] b_w        = '0;
  logic                 b_tick     = 1'b0;
  logic                 b_busy;
  logic                 b_ovr;
  logic                 b_spk_valid;
  logic [2:0]           b_spk_idx;

  lif_neuron_array #(
    .N_NEURONS(5), .V_WIDTH(VW), .THRESHOLD(THR), .LEAK_SHIFT(LS), .REFRACT(RF), .IDX_W(3)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_idx(b_in_idx),
    .in_weight(b_w), .tick(b_tick), .busy(b_busy), .tick_overrun(b_ovr),
    .spk_valid(b_spk_valid), .spk_ready(1'b1), .spk_idx(b_spk_idx)
  );

  int tests  = 0;
  int errors = 0;
  int exp_q[$];
  int mv[N];
  int macc[N];
  int mrefr[N];
  int busy_cycles = 0;
  int b_cnt  = 0;
  int b_last = -1;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; macc[i] = 0; mrefr[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_scan();
    int vn;
    for (int i = 0; i < N; i++) begin
      if (mrefr[i] > 0) begin
        mrefr[i]--; mv[i] = 0; macc[i] = 0;
      end else begin
        vn = clamp(mv[i] + macc[i] - (mv[i] >>> LS));
        macc[i] = 0;
        if (vn >= THR) begin
          exp_q.push_back(i); mv[i] = 0; mrefr[i] = RF;
        end else begin
          mv[i] = vn;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && busy) busy_cycles++;
    if (!rst && spk_valid && spk_ready) begin
      $display("[TB] spike accepted idx=%0d", spk_idx);
      if (exp_q.size() == 0) check("spk_unexpected", int'(spk_idx), -1);
      else check("spk_idx", int'(spk_idx), exp_q.pop_front());
    end
    if (!rst && b_spk_valid) begin
      b_cnt++; b_last = int'(b_spk_idx);
    end
  end

  task automatic send_ev(input int idx, input int w);
    @(posedge clk); #1;
    in_valid = 1'b1; in_idx = IW'(idx); in_weight = VW'(w);
    @(negedge clk);
    check("in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (idx < N) macc[idx] = clamp(macc[idx] + w);
    $display("[TB] event idx=%0d w=%0d", idx, w);
  endtask

  task automatic do_tick(input bit ev, input int idx, input int w);
    @(posedge clk); #1;
    busy_cycles = 0;
    tick = 1'b1; in_valid = ev; in_idx = IW'(idx); in_weight = VW'(w);
    @(posedge clk); #1;
    tick = 1'b0; in_valid = 1'b0;
    if (ev && idx < N) macc[idx] = clamp(macc[idx] + w);
    model_scan();
    $display("[TB] tick (event=%0d idx=%0d w=%0d), %0d spikes expected", ev, idx, w, exp_q.size());
  endtask

  task automatic wait_idle(input string tag, input int exp_cycles);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check({tag, "_timeout"}, n, 0);
    if (exp_cycles >= 0) check({tag, "_busy"}, busy_cycles, exp_cycles);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic b_run(input int idx, input int exp_cnt);
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_idx = 3'(idx); b_w = VW'(2000);
    @(negedge clk);
    check("b_in_ready", int'(b_in_ready), 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_cnt = 0;
    @(posedge clk); #1;
    b_tick = 1'b1;
    @(posedge clk); #1;
    b_tick = 1'b0;
    repeat (10) @(negedge clk);
    check("b_busy_done", int'(b_busy), 0);
    check("b_spike_count", b_cnt, exp_cnt);
    if (exp_cnt > 0) check("b_spike_idx", b_last, idx);
    $display("[TB] dut_b event idx=%0d -> %0d spikes", idx, b_cnt);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_spk_valid", int'(spk_valid), 0);
    check("rst_spk_idx", int'(spk_idx), 0);
    check("rst_overrun", int'(tick_overrun), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset in the middle of a scan with a spike held pending.
    send_ev(0, 1500);
    send_ev(1, 600);
    spk_ready = 1'b0;
    do_tick(1'b0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_spk_valid", int'(spk_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_spk_valid", int'(spk_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    spk_ready = 1'b1;
    do_tick(1'b0, 0, 0);
    wait_idle("empty_tick", N);

    // Integrate over two ticks, then fire.
    send_ev(1, 600);
    do_tick(1'b0, 0, 0);
    wait_idle("integrate", N);
    send_ev(1, 600);
    do_tick(1'b0, 0, 0);
    wait_idle("fire1", N);

    // Refractory period suppresses two ticks of strong input.
    for (int k = 0; k < 3; k++) begin
      send_ev(1, 2000);
      do_tick(1'b0, 0, 0);
      wait_idle("refract", N);
    end

    // Backpressure holds the first spike and stalls the scan.
    send_ev(0, 1500);
    send_ev(2, 1500);
    spk_ready = 1'b0;
    do_tick(1'b0, 0, 0);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_spk_valid", int'(spk_valid), 1);
      check("bp_spk_idx", int'(spk_idx), 0);
      check("bp_busy", int'(busy), 1);
    end
    @(posedge clk); #1;
    spk_ready = 1'b1;
    wait_idle("backpressure", -1);

    // Saturation in both directions on the last neuron.
    send_ev(3, 32767);
    send_ev(3, 32767);
    do_tick(1'b0, 0, 0);
    wait_idle("sat_pos", -1);
    for (int k = 0; k < 2; k++) begin
      do_tick(1'b0, 0, 0);
      wait_idle("sat_clear", N);
    end
    send_ev(3, -32768);
    send_ev(3, -32768);
    do_tick(1'b0, 0, 0);
    wait_idle("sat_neg", N);
    send_ev(3, 20000);
    do_tick(1'b0, 0, 0);
    wait_idle("sat_neg_follow", N);

    // Event coincident with tick, plus an ignored tick mid-scan.
    do_tick(1'b1, 2, 1200);
    @(posedge clk); #1;
    tick = 1'b1;
    @(negedge clk);
    check("ovr_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    tick = 1'b0;
    @(negedge clk);
    check("ovr_pulse", int'(tick_overrun), 1);
    @(negedge clk);
    check("ovr_pulse_end", int'(tick_overrun), 0);
    wait_idle("overrun", N);

    // Out-of-range indices on the five-neuron instance.
    b_run(5, 0);
    b_run(7, 0);
    b_run(4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, errors);
    $fatal(1);
  end

endmodule
